// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between the team's APB master and the apb_slave_mem completer.
interface apb_slave_mem_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed memory, with a fixed number of wait
// states and pslverr on out-of-range word addresses.
module apb_slave_mem #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic             pclk,
   input  logic             preset_n,
   apb_slave_mem_if.slave   bus
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_write;
   logic                  r_err;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_prdata;
   logic                  r_pready;
   logic                  r_pslverr;
   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   state_t                w_state_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_latch;
   logic                  w_complete;
   logic                  w_pready_nxt;
   logic                  w_pslverr_nxt;
   logic [ADDR_WIDTH-1:0] w_paddr;
   logic                  w_setup_err;
   logic                  w_write_sel;
   logic                  w_err_sel;
   logic [IDX_W-1:0]      w_idx_sel;
   logic [DATA_WIDTH-1:0] w_wdata_sel;

   // Full-width compare so upper address bits can never alias into the array
   assign w_paddr     = bus.paddr;
   assign w_setup_err = (64'(w_paddr) >= 64'(MEM_DEPTH));

   // Zero-wait completion happens on the setup edge, so use live bus values there
   assign w_write_sel = (r_state == S_IDLE) ? bus.pwrite            : r_write;
   assign w_err_sel   = (r_state == S_IDLE) ? w_setup_err           : r_err;
   assign w_idx_sel   = (r_state == S_IDLE) ? w_paddr[IDX_W-1:0]    : r_idx;
   assign w_wdata_sel = (r_state == S_IDLE) ? bus.pwdata            : r_wdata;

   // Next-state and response logic
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_latch       = 1'b0;
      w_complete    = 1'b0;
      w_pready_nxt  = r_pready;
      w_pslverr_nxt = r_pslverr;

      unique case (r_state)
         S_IDLE: begin
            if (bus.psel && !bus.penable) begin
               w_latch = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_complete  = 1'b1;
                  w_state_nxt = S_RESP;
               end else begin
                  w_cnt_nxt   = CNT_LOAD;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!bus.psel) begin
               w_state_nxt   = S_IDLE;
               w_pready_nxt  = 1'b0;
               w_pslverr_nxt = 1'b0;
            end else if (bus.penable) begin
               if (r_cnt == '0) begin
                  w_complete  = 1'b1;
                  w_state_nxt = S_RESP;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
         end
         S_RESP: begin
            w_state_nxt   = S_IDLE;
            w_pready_nxt  = 1'b0;
            w_pslverr_nxt = 1'b0;
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_pready_nxt  = 1'b0;
            w_pslverr_nxt = 1'b0;
         end
      endcase

      if (w_complete) begin
         w_pready_nxt  = 1'b1;
         w_pslverr_nxt = w_err_sel;
      end
   end

   // State and wait counter
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Setup-phase capture; access-phase bus changes are ignored
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_latch) begin
         r_write <= bus.pwrite;
         r_err   <= w_setup_err;
         r_idx   <= w_paddr[IDX_W-1:0];
         r_wdata <= bus.pwdata;
      end
   end

   // Registered response outputs; prdata only changes on a completing read
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else begin
         r_pready  <= w_pready_nxt;
         r_pslverr <= w_pslverr_nxt;
         if (w_complete && !w_write_sel) begin
            r_prdata <= w_err_sel ? '0 : r_mem[w_idx_sel];
         end
      end
   end

   // Memory array, cleared by reset, written only on an in-range completion
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_complete && w_write_sel && !w_err_sel) begin
         r_mem[w_idx_sel] <= w_wdata_sel;
      end
   end

   assign bus.prdata  = r_prdata;
   assign bus.pready  = r_pready;
   assign bus.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a 2-wait-state instance and a zero-wait instance.
module tb_apb_slave_mem;

   logic        pclk;
   logic        preset_n;
   logic        t_psel2;
   logic        t_psel0;
   logic        t_penable;
   logic        t_pwrite;
   logic [15:0] t_paddr;
   logic [31:0] t_pwdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] rd;
   logic        er;
   int          acc;

   apb_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus2 ();
   apb_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();

   assign bus2.psel    = t_psel2;
   assign bus2.penable = t_penable;
   assign bus2.pwrite  = t_pwrite;
   assign bus2.paddr   = t_paddr;
   assign bus2.pwdata  = t_pwdata;
   assign bus0.psel    = t_psel0;
   assign bus0.penable = t_penable;
   assign bus0.pwrite  = t_pwrite;
   assign bus0.paddr   = t_paddr;
   assign bus0.pwdata  = t_pwdata;

   apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
      .pclk     (pclk),
      .preset_n (preset_n),
      .bus      (bus2)
   );

   apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
      .pclk     (pclk),
      .preset_n (preset_n),
      .bus      (bus0)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? bus0.pready : bus2.pready;
   endfunction

   // One APB transfer; sel=0 targets the 2-wait instance, sel=1 the zero-wait one.
   // acc_addr is driven on paddr during the access phase. acc counts access cycles
   // up to and including the one in which pready is seen high.
   task automatic xfer(input bit sel, input bit wr, input logic [15:0] addr,
                       input logic [15:0] acc_addr, input logic [31:0] data,
                       output logic [31:0] rdata, output logic err, output int cycles);
      @(negedge pclk);
      t_psel2   = !sel;
      t_psel0   = sel;
      t_penable = 1'b0;
      t_pwrite  = wr;
      t_paddr   = addr;
      t_pwdata  = data;
      @(negedge pclk);
      t_penable = 1'b1;
      t_paddr   = acc_addr;
      cycles    = 1;
      while (!rdy(sel) && cycles < 16) begin
         @(negedge pclk);
         cycles++;
      end
      rdata = sel ? bus0.prdata  : bus2.prdata;
      err   = sel ? bus0.pslverr : bus2.pslverr;
   endtask

   task automatic bus_idle();
      @(negedge pclk);
      t_psel2   = 1'b0;
      t_psel0   = 1'b0;
      t_penable = 1'b0;
   endtask

   initial begin
      preset_n  = 1'b0;
      t_psel2   = 1'b0;
      t_psel0   = 1'b0;
      t_penable = 1'b0;
      t_pwrite  = 1'b0;
      t_paddr   = '0;
      t_pwdata  = '0;
      repeat (3) @(negedge pclk);
      check("rst_prdata",  bus2.prdata,  32'h0);
      check("rst_pready",  32'(bus2.pready),  32'h0);
      check("rst_pslverr", 32'(bus2.pslverr), 32'h0);
      check("rst_pready0", 32'(bus0.pready),  32'h0);
      preset_n = 1'b1;
      @(negedge pclk);

      // Write then read with two wait states
      xfer(1'b0, 1'b1, 16'h0010, 16'h0010, 32'hDEADBEEF, rd, er, acc);
      check("wr10_cycles", 32'(acc), 32'd3);
      check("wr10_err",    32'(er),  32'h0);
      xfer(1'b0, 1'b0, 16'h0010, 16'h0010, 32'h0, rd, er, acc);
      check("rd10_cycles", 32'(acc), 32'd3);
      check("rd10_data",   rd,       32'hDEADBEEF);
      check("rd10_err",    32'(er),  32'h0);
      bus_idle();
      repeat (2) @(negedge pclk);
      check("prdata_hold", bus2.prdata, 32'hDEADBEEF);
      check("pready_low",  32'(bus2.pready), 32'h0);

      // Out-of-range and non-aliasing upper bits
      xfer(1'b0, 1'b1, 16'h0100, 16'h0100, 32'h12345678, rd, er, acc);
      check("wr100_err",  32'(er), 32'h1);
      bus_idle();
      check("err_cleared", 32'(bus2.pslverr), 32'h0);
      xfer(1'b0, 1'b0, 16'h0100, 16'h0100, 32'h0, rd, er, acc);
      check("rd100_err",  32'(er), 32'h1);
      check("rd100_data", rd,      32'h0);
      xfer(1'b0, 1'b1, 16'h0110, 16'h0110, 32'hBAD0BAD0, rd, er, acc);
      check("wr110_err",  32'(er), 32'h1);
      xfer(1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0, rd, er, acc);
      check("rd0_data",   rd,      32'h0);
      check("rd0_err",    32'(er), 32'h0);
      xfer(1'b0, 1'b0, 16'h0010, 16'h0010, 32'h0, rd, er, acc);
      check("no_alias",   rd,      32'hDEADBEEF);
      xfer(1'b0, 1'b1, 16'h00FF, 16'h00FF, 32'h0BADF00D, rd, er, acc);
      check("wrFF_err",   32'(er), 32'h0);
      xfer(1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0, rd, er, acc);
      check("rdFF_data",  rd,      32'h0BADF00D);
      bus_idle();

      // Zero-wait instance, back-to-back
      xfer(1'b1, 1'b1, 16'h00FF, 16'h00FF, 32'hA5A5A5A5, rd, er, acc);
      check("z_wr_cycles", 32'(acc), 32'd1);
      check("z_wr_err",    32'(er),  32'h0);
      xfer(1'b1, 1'b0, 16'h00FF, 16'h00FF, 32'h0, rd, er, acc);
      check("z_rd_cycles", 32'(acc), 32'd1);
      check("z_rd_data",   rd,       32'hA5A5A5A5);
      xfer(1'b1, 1'b0, 16'h0100, 16'h0100, 32'h0, rd, er, acc);
      check("z_rd100_err", 32'(er),  32'h1);
      check("z_rd100_data", rd,      32'h0);
      bus_idle();

      // Abort: psel dropped during the first wait cycle
      @(negedge pclk);
      t_psel2   = 1'b1;
      t_penable = 1'b0;
      t_pwrite  = 1'b1;
      t_paddr   = 16'h0005;
      t_pwdata  = 32'h11111111;
      @(negedge pclk);
      t_psel2   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         check("abort_pready", 32'(bus2.pready), 32'h0);
      end
      xfer(1'b0, 1'b0, 16'h0005, 16'h0005, 32'h0, rd, er, acc);
      check("abort_rd5", rd, 32'h0);
      bus_idle();

      // Access-phase paddr change is ignored
      xfer(1'b0, 1'b1, 16'h0001, 16'h0002, 32'h00000077, rd, er, acc);
      xfer(1'b0, 1'b0, 16'h0001, 16'h0001, 32'h0, rd, er, acc);
      check("stable_rd1", rd, 32'h00000077);
      xfer(1'b0, 1'b0, 16'h0002, 16'h0002, 32'h0, rd, er, acc);
      check("stable_rd2", rd, 32'h0);
      bus_idle();

      // Reset asserted in the wait phase of a second write
      xfer(1'b0, 1'b1, 16'h0003, 16'h0003, 32'h0000CAFE, rd, er, acc);
      xfer(1'b0, 1'b0, 16'h0003, 16'h0003, 32'h0, rd, er, acc);
      check("pre_rst_rd3", rd, 32'h0000CAFE);
      bus_idle();
      @(negedge pclk);
      t_psel2   = 1'b1;
      t_penable = 1'b0;
      t_pwrite  = 1'b1;
      t_paddr   = 16'h0004;
      t_pwdata  = 32'h00000055;
      @(negedge pclk);
      t_penable = 1'b1;
      #2;
      preset_n = 1'b0;
      #1;
      check("midrst_prdata",  bus2.prdata,  32'h0);
      check("midrst_pready",  32'(bus2.pready),  32'h0);
      check("midrst_pslverr", 32'(bus2.pslverr), 32'h0);
      t_psel2   = 1'b0;
      t_penable = 1'b0;
      @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
      xfer(1'b0, 1'b0, 16'h0003, 16'h0003, 32'h0, rd, er, acc);
      check("post_rst_rd3", rd, 32'h0);
      xfer(1'b0, 1'b0, 16'h0004, 16'h0004, 32'h0, rd, er, acc);
      check("post_rst_rd4", rd, 32'h0);
      bus_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB3 completer that terminates transfers issued by the team's APB master. It holds a word-addressed register/memory array of MEM_DEPTH words. The block inserts a fixed, programmable number of wait states, returns read data, commits write data, and flags out-of-range addresses with pslverr. It sits on the peripheral side of the APB bus as the standard test and peripheral endpoint.

Parameters:
ADDR_WIDTH, 16, width of paddr; paddr is a word index, not a byte address.
DATA_WIDTH, 32, width of pwdata, prdata and each memory word.
MEM_DEPTH, 256, number of words; valid addresses are 0 to MEM_DEPTH-1.
WAIT_CYCLES, 2, wait states per transfer; allowed range 0 to 15.

Ports:
pclk  input  1  bus clock; all state updates on the rising edge.
preset_n  input  1  reset, asynchronous, active-low.
psel  input  1  completer select from the master.
penable  input  1  access-phase indicator.
pwrite  input  1  1 = write, 0 = read; sampled at the setup edge.
paddr  input  ADDR_WIDTH  word address; sampled at the setup edge.
pwdata  input  DATA_WIDTH  write data; sampled at the setup edge.
prdata  output  DATA_WIDTH  read data; registered.
pready  output  1  transfer-complete indicator; registered.
pslverr  output  1  error response; meaningful only while pready=1.

Behaviour:
- Clock and reset: one clock (pclk). Reset preset_n is asynchronous, active-low.
- Reset values: prdata=0, pready=0, pslverr=0, state=IDLE, wait counter=0. All MEM_DEPTH words are cleared to 0.
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with psel=1 and penable=0 (setup phase), latch pwrite, paddr and pwdata.
  - Compute err = (paddr >= MEM_DEPTH).
  - If WAIT_CYCLES=0: go directly to RESP and perform the completion actions below at this same edge.
  - Otherwise: load cnt = WAIT_CYCLES-1 and go to WAIT.
- WAIT (pready=0):
  - Each edge with psel=1 and penable=1: if cnt=0, perform the completion actions and go to RESP; otherwise decrement cnt.
- Completion actions:
  - Set pready<=1 and pslverr<=err.
  - Read, no error: prdata<=mem[addr].
  - Read, error: prdata<=0.
  - Write, no error: mem[addr]<=latched wdata.
  - Write, error: memory is untouched.
  - prdata is not modified by writes.
- RESP (pready=1):
  - The master samples the response at the next edge.
  - At that edge: pready<=0, pslverr<=0, go to IDLE.
  - A new setup phase is therefore accepted one cycle after completion, which matches the master's ACCESS to SETUP back-to-back sequence.
- Latency: the access phase lasts exactly WAIT_CYCLES+1 cycles, i.e. penable is high for WAIT_CYCLES+1 edges. Write commit and read capture occur on the edge that raises pready.
- Sampling rule: paddr, pwrite and pwdata changes during the access phase are ignored; only setup-edge values are used.
- prdata holds its last read value between transfers.
- Abort: if psel=0 on any edge while in WAIT or RESP, go to IDLE with pready<=0 and pslverr<=0. In WAIT this abort happens with no write commit.
- Boundaries:
  - paddr = MEM_DEPTH-1 is valid.
  - paddr = MEM_DEPTH is an error.
  - Upper paddr bits are never truncated to alias into the array.
- Reset asserted mid-transfer: all outputs clear immediately with no write commit. The memory clears as well.

Test Plan:
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x0010, then read addr 0x0010. pready rises on the 3rd access cycle; prdata=0xDEADBEEF; pslverr=0 both times.
- Out-of-range, MEM_DEPTH=256: write 0x12345678 to addr 0x0100, then read addr 0x0100. Both complete with pslverr=1 and the read returns prdata=0. A subsequent read of addr 0x0000 returns 0 with pslverr=0.
- Zero-wait build, WAIT_CYCLES=0: back-to-back write 0xA5A5A5A5 to addr 0x00FF then read addr 0x00FF. pready=1 in the first access cycle of each; the read returns 0xA5A5A5A5.
- Abort: start a write of 0x11111111 to addr 0x0005 and drop psel during the 1st wait cycle. pready stays 0; a later read of addr 0x0005 returns 0.
- Reset mid-op: write 0x0000CAFE to addr 0x0003, then assert preset_n=0 during the WAIT of a second write. pready, pslverr and prdata clear asynchronously; after release, a read of addr 0x0003 returns 0.
- Access-phase stability: change paddr from 0x0001 to 0x0002 while penable=1 on a write of 0x77. Only addr 0x0001 holds 0x77; addr 0x0002 reads 0.
